rf_write_arbiter: RTL and testbench

Shares the single write port of the register file among NUM_REQ writeback sources (ALU, load unit, multi-cycle unit) using round-robin arbitration and a valid/ready handshake. It drives the register file's en/rd/data write inputs from a registered output stage. It also keeps a one-bit-per-register pending-write scoreboard, so issue logic can detect RAW and WAW hazards on rs/rt/rd.

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_write_arbiter_rr_arbiter.sv | 44 ++++
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
// Pure declarations: no logic, no latency.
// Not applicable to backpressure; consumers define their own handshakes.
package rf_write_arbiter_pkg;

  localparam int GPR_WIDTH          = 32;
  localparam int REGISTER_FILE_SIZE = 16;
  localparam int ADDR_W             = 5;
  localparam int WB_NUM_REQ         = 3;
  localparam int RF_IDX_W           = $clog2(REGISTER_FILE_SIZE);

  // True when a register address names an implemented architectural register.
  function automatic logic rf_addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(REGISTER_FILE_SIZE));
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: request vector + priority pointer -> one-hot grant + next pointer.
// Purely combinational, zero latency.
// No backpressure of its own; the caller masks requests to stall arbitration.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_next_ptr
);

  int w_best_j;
  int w_best_dist;
  int w_dist;

  // Pick the requester closest to the pointer, walking upward modulo N.
  always_comb begin
    w_best_j    = N;
    w_best_dist = N;
    w_dist      = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_j    = j;
      end
    end
  end

  // Expand the winner into a one-hot grant and the pointer just past it.
  always_comb begin
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    for (int j = 0; j < N; j++) begin
      if (j == w_best_j) begin
        o_gnt[j]   = 1'b1;
        o_next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among writeback sources and tracks pending writes.
// Grant is combinational; the register-file write appears 1 cycle after the handshake.
// rf_hold or reset withholds all grants; sources keep wb_valid/wb_rd/wb_data until granted.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           wb_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    wb_rd,
  input  logic [NUM_REQ*GPR_WIDTH-1:0] wb_data,
  output logic [NUM_REQ-1:0]           wb_ready,
  input  logic                         rf_hold,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_rd,
  output logic                         issue_stall,
  input  logic [ADDR_W-1:0]            rs,
  input  logic [ADDR_W-1:0]            rt,
  output logic                         busy_rs,
  output logic                         busy_rt,
  output logic                         rf_en,
  output logic [ADDR_W-1:0]            rf_rd,
  output logic [GPR_WIDTH-1:0]         rf_data,
  output logic                         addr_err
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]                   r_ptr;
  logic [REGISTER_FILE_SIZE-1:0]   r_pending;
  logic                            r_rf_en;
  logic [ADDR_W-1:0]               r_rf_rd;
  logic [GPR_WIDTH-1:0]            r_rf_data;
  logic                            r_addr_err;

  logic [NUM_REQ-1:0]              w_req;
  logic [NUM_REQ-1:0]              w_gnt;
  logic [PW-1:0]                   w_next_ptr;
  logic                            w_hs;
  logic [ADDR_W-1:0]               w_sel_rd;
  logic [GPR_WIDTH-1:0]            w_sel_data;
  logic                            w_sel_in_range;
  logic                            w_issue_in_range;
  logic                            w_issue_pend;
  logic                            w_set;

  // No grant may be offered while frozen or while reset is asserted.
  assign w_req = wb_valid & {NUM_REQ{rst & ~rf_hold}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .i_req      (w_req),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_next_ptr)
  );

  assign wb_ready = w_gnt;
  assign w_hs     = |w_gnt;

  // One-hot select of the granted requester's destination and data.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_rd   = wb_rd[i*ADDR_W +: ADDR_W];
        w_sel_data = wb_data[i*GPR_WIDTH +: GPR_WIDTH];
      end
    end
  end

  assign w_sel_in_range = rf_addr_in_range(w_sel_rd);

  // Priority pointer advances past whoever just completed a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_next_ptr;
    end
  end

  // Registered write stage; out-of-range destinations are swallowed and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_en    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_rf_en <= w_hs & w_sel_in_range;
      if (w_hs) begin
        r_rf_rd   <= w_sel_rd;
        r_rf_data <= w_sel_data;
        if (!w_sel_in_range) begin
          r_addr_err <= 1'b1;
        end
      end
    end
  end

  assign rf_en    = r_rf_en;
  assign rf_rd    = r_rf_rd;
  assign rf_data  = r_rf_data;
  assign addr_err = r_addr_err;

  // Hazard lookups read current scoreboard state; a clear landing this edge is not yet visible.
  assign w_issue_in_range = rf_addr_in_range(issue_rd);
  assign w_issue_pend     = w_issue_in_range & r_pending[issue_rd[RF_IDX_W-1:0]];
  assign issue_stall      = issue_valid & w_issue_pend;
  assign w_set            = issue_valid & w_issue_in_range & ~issue_stall;
  assign busy_rs          = rf_addr_in_range(rs) & r_pending[rs[RF_IDX_W-1:0]];
  assign busy_rt          = rf_addr_in_range(rt) & r_pending[rt[RF_IDX_W-1:0]];

  // Scoreboard: clear on the edge the register file captures, then apply any new reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      if (r_rf_en) begin
        r_pending[r_rf_rd[RF_IDX_W-1:0]] <= 1'b0;
      end
      if (w_set) begin
        r_pending[issue_rd[RF_IDX_W-1:0]] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic.
// Outputs are compared every cycle against a behavioural model of the arbitration rules.
// Requesters obey the hold-stable-until-granted rule; drops before the grant are exercised.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int N   = WB_NUM_REQ;
  localparam int RFS = REGISTER_FILE_SIZE;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           wb_valid;
  logic [N*ADDR_W-1:0]    wb_rd;
  logic [N*GPR_WIDTH-1:0] wb_data;
  logic [N-1:0]           wb_ready;
  logic                   rf_hold;
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_rd;
  logic                   issue_stall;
  logic [ADDR_W-1:0]      rs;
  logic [ADDR_W-1:0]      rt;
  logic                   busy_rs;
  logic                   busy_rt;
  logic                   rf_en;
  logic [ADDR_W-1:0]      rf_rd;
  logic [GPR_WIDTH-1:0]   rf_data;
  logic                   addr_err;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rf_hold     (rf_hold),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .rs          (rs),
    .rt          (rt),
    .busy_rs     (busy_rs),
    .busy_rt     (busy_rt),
    .rf_en       (rf_en),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .addr_err    (addr_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  int                   m_ptr;
  bit                   m_pend [RFS];
  bit                   m_en;
  logic [ADDR_W-1:0]    m_rd;
  logic [GPR_WIDTH-1:0] m_data;
  bit                   m_err;
  int                   m_last_g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst !== 1'b1 || rf_hold) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (wb_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_busy(input logic [ADDR_W-1:0] a);
    if (int'(a) < RFS) return m_pend[int'(a)];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int r = 0; r < RFS; r++) m_pend[r] = 1'b0;
    m_en = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0; m_last_g = -1;
  endtask

  task automatic model_edge();
    int g;
    bit stall;
    logic [ADDR_W-1:0] d;
    g     = model_grant();
    stall = issue_valid && m_busy(issue_rd);
    if (m_en) m_pend[int'(m_rd)] = 1'b0;
    if (issue_valid && int'(issue_rd) < RFS && !stall) m_pend[int'(issue_rd)] = 1'b1;
    if (g >= 0) begin
      d      = wb_rd[g*ADDR_W +: ADDR_W];
      m_rd   = d;
      m_data = wb_data[g*GPR_WIDTH +: GPR_WIDTH];
      m_en   = (int'(d) < RFS);
      if (int'(d) >= RFS) m_err = 1'b1;
      m_ptr  = (g + 1) % N;
    end else begin
      m_en = 1'b0;
    end
    m_last_g = g;
  endtask

  task automatic compare_all();
    int g;
    logic [N-1:0] er;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("wb_ready",    wb_ready,    er);
    chk("issue_stall", issue_stall, issue_valid && m_busy(issue_rd));
    chk("busy_rs",     busy_rs,     m_busy(rs));
    chk("busy_rt",     busy_rt,     m_busy(rt));
    chk("rf_en",       rf_en,       m_en);
    chk("rf_rd",       rf_rd,       m_rd);
    chk("rf_data",     rf_data,     m_data);
    chk("addr_err",    addr_err,    m_err);
  endtask

  // One clock: compare settled outputs, clock the model alongside the DUT, return at negedge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (rst === 1'b1) model_edge();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] d,
                         input logic [GPR_WIDTH-1:0] x);
    wb_valid[i] = v;
    wb_rd[i*ADDR_W +: ADDR_W] = d;
    wb_data[i*GPR_WIDTH +: GPR_WIDTH] = x;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; wb_valid = '0; wb_rd = '0; wb_data = '0; rf_hold = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; rs = '0; rt = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_rf_en", rf_en, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_wb_ready", wb_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("idle_rf_en", rf_en, 0);

    // Single requester
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_rdy", wb_ready, 3'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("single_en", rf_en, 1);
    chk("single_rd", rf_rd, 5);
    chk("single_data", rf_data, 32'hDEADBEEF);
    tick();

    // Round robin from pointer 0, then a one-cycle hold
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11111111);
    set_req(1, 1'b1, 5'd2, 32'h22222222);
    set_req(2, 1'b1, 5'd3, 32'h33333333);
    #1 chk("rr_0", wb_ready, 3'b001); tick();
    #1 chk("rr_1", wb_ready, 3'b010); tick();
    #1 chk("rr_2", wb_ready, 3'b100); tick();
    #1 chk("rr_3", wb_ready, 3'b001); tick();
    rf_hold = 1'b1;
    #1 chk("rr_hold", wb_ready, 3'b000); tick();
    rf_hold = 1'b0;
    #1 chk("rr_resume", wb_ready, 3'b010); tick();
    wb_valid = '0;
    tick();

    // Scoreboard reserve / WAW stall / clear after write (pointer is now 2)
    issue_valid = 1'b1; issue_rd = 5'd3; rs = 5'd3; rt = 5'd4;
    #1 chk("sb_busy_pre", busy_rs, 0);
    tick();
    #1;
    chk("sb_busy", busy_rs, 1);
    chk("sb_waw", issue_stall, 1);
    tick();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'hCAFE0003);
    #1 chk("sb_wr_rdy", wb_ready, 3'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("sb_wr_en", rf_en, 1);
    chk("sb_busy_hold", busy_rs, 1);
    tick();
    #1 chk("sb_busy_clr", busy_rs, 0);

    // Out-of-range destination (pointer is now 1)
    set_req(2, 1'b1, 5'd20, 32'h000000AB);
    #1 chk("oor_rdy", wb_ready, 3'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("oor_en", rf_en, 0);
    chk("oor_err", addr_err, 1);
    for (int c = 0; c < 3; c++) tick();
    chk("oor_sticky", addr_err, 1);

    // Reset while a handshake is in flight and register 7 is pending
    issue_valid = 1'b1; issue_rd = 5'd7; rs = 5'd7;
    tick();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h99999999);
    #1;
    chk("mr_busy7", busy_rs, 1);
    chk("mr_hs", |wb_ready, 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mr_en", rf_en, 0);
    chk("mr_busy", busy_rs, 0);
    chk("mr_err", addr_err, 0);
    chk("mr_rdy", wb_ready, 0);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 1'b1, 5'd10, 32'h10101010);
    set_req(2, 1'b1, 5'd11, 32'h11111111);
    #1 chk("mr_ptr0", wb_ready, 3'b001);
    tick();
    wb_valid = '0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      for (int i = 0; i < N; i++) begin
        if (wb_valid[i]) begin
          if (m_last_g == i) set_req(i, 1'b0, 5'd0, 32'h0);
          else if ($urandom_range(0, 15) == 0) set_req(i, 1'b0, 5'd0, 32'h0);
        end
        if (!wb_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 5'($urandom_range(0, 19)), $urandom);
      end
      rf_hold     = ($urandom_range(0, 7) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd    = 5'($urandom_range(0, 17));
      rs          = 5'($urandom_range(0, 19));
      rt          = 5'($urandom_range(0, 19));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
